pulse_height_usb_tx: RTL and testbench



---
 rtl/pulse_height_usb_tx_pkg.sv | 44 ++++
 rtl/pulse_height_usb_tx_if.sv | 21 ++
 rtl/pulse_height_usb_tx_fifo.sv | 52 +++++
 rtl/pulse_height_usb_tx.sv | 142 ++++++++++++++
 tb/tb_pulse_height_usb_tx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_height_usb_tx_pkg.sv
// Shared types and constants for the pulse-height USB transmitter.
// PH_USB_TX_SYNC_EN prefixes every word with a 0xA5 sync byte (5-byte frames).
package ph_usb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_TXE,
        STROBE_HI,
        STROBE_LO
    } tx_state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         DROP_CNT_W     = 16;

`ifdef PH_USB_TX_SYNC_EN
    localparam int FRAME_BYTES = BYTES_PER_WORD + 1;
`else
    localparam int FRAME_BYTES = BYTES_PER_WORD;
`endif

    // Byte idx of the on-wire frame for a word, LSB first after the optional sync byte.
    function automatic logic [7:0] frame_byte(input logic [31:0] word, input logic [2:0] idx);
        logic [2:0] k;
        logic [7:0] b;
`ifdef PH_USB_TX_SYNC_EN
        k = idx - 3'd1;
`else
        k = idx;
`endif
        case (k)
            3'd0:    b = word[7:0];
            3'd1:    b = word[15:8];
            3'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
`ifdef PH_USB_TX_SYNC_EN
        if (idx == 3'd0) b = SYNC_BYTE;
`endif
        return b;
    endfunction

endpackage

// File: rtl/pulse_height_usb_tx_if.sv
// Pulse-height input strobe plus FT245-style USB FIFO bus.
// master = transmitter side, slave = producer/USB-chip side.
interface pulse_height_usb_tx_if;
    logic [31:0] ph_data;
    logic        ph_valid;
    logic        txe;
    logic        wr;
    logic        rd;
    logic [7:0]  data_out;
    logic        data_oe;

    modport master (
        input  ph_data, ph_valid, txe,
        output wr, rd, data_out, data_oe
    );

    modport slave (
        output ph_data, ph_valid, txe,
        input  wr, rd, data_out, data_oe
    );
endinterface

// File: rtl/pulse_height_usb_tx_fifo.sv
// Synchronous FIFO with show-ahead read; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module ph_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // When full, the freed slot is the one being read, so the old word is
    // still seen on dout this cycle and the new one lands behind it.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!nRST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/pulse_height_usb_tx.sv
// Buffers pulse-height words and serializes them LSB-first onto an FT245 bus.
// Define PH_USB_TX_SYNC_EN to precede each word with sync byte 0xA5.
module pulse_height_usb_tx
    import ph_usb_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int WR_HIGH = 2,
    parameter int WR_LOW  = 2
) (
    input  logic                    clk,
    input  logic                    nRST,
    input  logic                    enable,
    pulse_height_usb_tx_if.master   bus,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    overflow,
    output logic [DROP_CNT_W-1:0]   drop_count
);
    localparam int         CNT_W    = $clog2(WR_HIGH > WR_LOW ? WR_HIGH : WR_LOW) + 1;
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

    tx_state_t        state, state_nxt;
    logic [31:0]      shift_reg, shift_nxt;
    logic [2:0]       byte_idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             wr_q, wr_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             oe_q, oe_nxt;

    logic [31:0]      fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic             drop;

    assign push = bus.ph_valid && enable;
    assign drop = push && fifo_full && !pop;

    ph_sync_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
        .clk   (clk),
        .nRST  (nRST),
        .push  (push),
        .pop   (pop),
        .din   (bus.ph_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        idx_nxt   = byte_idx;
        cnt_nxt   = cnt;
        wr_nxt    = wr_q;
        data_nxt  = data_q;
        oe_nxt    = oe_q;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && enable) state_nxt = LOAD;
            end
            LOAD: begin
                pop       = 1'b1;
                shift_nxt = fifo_dout;
                idx_nxt   = 3'd0;
                oe_nxt    = 1'b1;
                data_nxt  = frame_byte(fifo_dout, 3'd0);
                state_nxt = WAIT_TXE;
            end
            WAIT_TXE: begin
                if (!bus.txe) begin
                    wr_nxt    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = STROBE_HI;
                end
            end
            STROBE_HI: begin
                if (cnt == CNT_W'(WR_HIGH - 1)) begin
                    wr_nxt    = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = STROBE_LO;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STROBE_LO: begin
                if (cnt == CNT_W'(WR_LOW - 1)) begin
                    cnt_nxt = '0;
                    // enable is only consulted at word boundaries so a word is never torn.
                    if (byte_idx == LAST_IDX) begin
                        if (!fifo_empty && enable) begin
                            state_nxt = LOAD;
                        end else begin
                            oe_nxt    = 1'b0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        idx_nxt   = byte_idx + 3'd1;
                        data_nxt  = frame_byte(shift_reg, byte_idx + 3'd1);
                        state_nxt = WAIT_TXE;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRST) begin
            state      <= IDLE;
            shift_reg  <= '0;
            byte_idx   <= '0;
            cnt        <= '0;
            wr_q       <= 1'b0;
            data_q     <= '0;
            oe_q       <= 1'b0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            byte_idx  <= idx_nxt;
            cnt       <= cnt_nxt;
            wr_q      <= wr_nxt;
            data_q    <= data_nxt;
            oe_q      <= oe_nxt;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end

    assign bus.wr       = wr_q;
    assign bus.rd       = 1'b1;
    assign bus.data_out = data_q;
    assign bus.data_oe  = oe_q;
endmodule

// File: tb/tb_pulse_height_usb_tx.sv
// Directed bench for pulse_height_usb_tx: bytes are captured on wr falling edges
// and compared against hand-built frames.
module tb_pulse_height_usb_tx;
    localparam int DEPTH   = 16;
    localparam int WR_HIGH = 2;
    localparam int WR_LOW  = 2;
`ifdef PH_USB_TX_SYNC_EN
    localparam int FRAME = 5;
    localparam bit SYNC  = 1'b1;
`else
    localparam int FRAME = 4;
    localparam bit SYNC  = 1'b0;
`endif
    localparam int BYTE_CYC = 1 + WR_HIGH + WR_LOW;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        enable = 1'b0;
    logic [4:0]  fifo_count;
    logic        overflow;
    logic [15:0] drop_count;

    pulse_height_usb_tx_if bus();

    pulse_height_usb_tx #(.DEPTH(DEPTH), .WR_HIGH(WR_HIGH), .WR_LOW(WR_LOW)) dut (
        .clk        (clk),
        .nRST       (nRST),
        .enable     (enable),
        .bus        (bus),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    // Bus monitor: byte committed on each wr falling edge.
    logic [7:0] got[$];
    int         pulses[$];
    int         run = 0;
    logic       prev_wr = 1'b0;
    int         oe_cyc = 0;
    int         wr_cyc = 0;

    always @(negedge clk) begin
        if (prev_wr && !bus.wr) begin
            got.push_back(bus.data_out);
            pulses.push_back(run);
        end
        run     <= bus.wr ? run + 1 : 0;
        prev_wr <= bus.wr;
        if (bus.data_oe) oe_cyc <= oe_cyc + 1;
        if (bus.wr)      wr_cyc <= wr_cyc + 1;
    end

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        bus.ph_data  = w;
        bus.ph_valid = 1'b1;
        step();
        bus.ph_valid = 1'b0;
    endtask

    task automatic add_word(input logic [31:0] w);
        if (SYNC) exp_q.push_back(8'hA5);
        exp_q.push_back(w[7:0]);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[23:16]);
        exp_q.push_back(w[31:24]);
    endtask

    task automatic check_bytes(input string tag, input int base);
        check({tag, "_nbytes"}, got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got.size())
                check($sformatf("%s[%0d]", tag, i), got[base + i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic wait_drained(input string tag, input int bound);
        int i = 0;
        while (i < bound && !(bus.data_oe == 1'b0 && fifo_count == 0)) begin
            step();
            i++;
        end
        check({tag, "_drained"}, (bus.data_oe == 1'b0 && fifo_count == 0), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int pb;
        int oe0;
        int wr0;
        int i;
        logic [31:0] w;
        logic [7:0]  first_byte;

        bus.ph_data  = '0;
        bus.ph_valid = 1'b0;
        bus.txe      = 1'b1;
        step(3);

        check("rst_wr", bus.wr, 0);
        check("rst_rd", bus.rd, 1);
        check("rst_data_out", bus.data_out, 0);
        check("rst_data_oe", bus.data_oe, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drops", drop_count, 0);

        nRST   = 1'b1;
        enable = 1'b1;
        bus.txe = 1'b0;
        step();

        // Single word, txe already low.
        base = got.size(); pb = pulses.size(); oe0 = oe_cyc; wr0 = wr_cyc;
        push(32'h12345678);
        wait_drained("single", 200);
        add_word(32'h12345678);
        check_bytes("single", base);
        check("single_oe_cycles", oe_cyc - oe0, BYTE_CYC * FRAME);
        check("single_wr_cycles", wr_cyc - wr0, WR_HIGH * FRAME);
        for (int k = pb; k < pulses.size(); k++)
            check($sformatf("single_pulse%0d", k - pb), pulses[k], WR_HIGH);
        check("single_oe_off", bus.data_oe, 0);

        // TXE stall with the word parked in WAIT_TXE, then overflow behind it.
        bus.txe = 1'b1;
        base = got.size();
        push(32'h12345678);
        step(2);
        wr0 = wr_cyc;
        step(50);
        first_byte = SYNC ? 8'hA5 : 8'h78;
        check("stall_wr_cycles", wr_cyc - wr0, 0);
        check("stall_wr", bus.wr, 0);
        check("stall_oe", bus.data_oe, 1);
        check("stall_data", bus.data_out, first_byte);

        for (int k = 1; k <= 18; k++) begin
            w = {8'hB0 + 8'(k), 8'hA0 + 8'(k), 8'h90 + 8'(k), 8'h80 + 8'(k)};
            push(w);
        end
        check("ovf_count", fifo_count, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_count, 2);

        bus.txe = 1'b0;
        step();
        check("txe_release_wr", bus.wr, 1);

        // Push lands exactly in the LOAD cycle that pops the next word.
        step(BYTE_CYC * FRAME - 1);
        check("prepop_count", fifo_count, 16);
        bus.ph_data  = 32'hDEADBEEF;
        bus.ph_valid = 1'b1;
        step();
        bus.ph_valid = 1'b0;
        check("fullpop_count", fifo_count, 16);
        check("fullpop_drops", drop_count, 2);

        wait_drained("ovf", 3000);
        add_word(32'h12345678);
        for (int k = 1; k <= 16; k++)
            add_word({8'hB0 + 8'(k), 8'hA0 + 8'(k), 8'h90 + 8'(k), 8'h80 + 8'(k)});
        add_word(32'hDEADBEEF);
        check_bytes("drain", base);
        check("drain_drops", drop_count, 2);

        // enable falls after the first byte of a word with two more queued.
        bus.txe = 1'b1;
        base = got.size();
        push(32'hA4A3A2A1);
        push(32'hB4B3B2B1);
        push(32'hC4C3C2C1);
        step(2);
        check("en_queued", fifo_count, 2);
        bus.txe = 1'b0;
        i = 0;
        while (i < 50 && got.size() == base) begin
            step();
            i++;
        end
        check("en_first_byte_seen", got.size() > base, 1);
        enable = 1'b0;
        i = 0;
        while (i < 100 && bus.data_oe) begin
            step();
            i++;
        end
        check("en_oe_off", bus.data_oe, 0);
        add_word(32'hA4A3A2A1);
        check_bytes("en_word", base);
        check("en_count", fifo_count, 2);
        push(32'hDEAD0000);
        step(10);
        check("en_ignored_count", fifo_count, 2);
        check("en_ignored_drops", drop_count, 2);
        check("en_hold_idle", bus.data_oe, 0);

        base = got.size();
        enable = 1'b1;
        wait_drained("resume", 300);
        add_word(32'hB4B3B2B1);
        add_word(32'hC4C3C2C1);
        check_bytes("resume", base);

        // Reset during STROBE_HI.
        push(32'h54535251);
        push(32'h64636261);
        i = 0;
        while (i < 20 && !bus.wr) begin
            step();
            i++;
        end
        check("prereset_wr", bus.wr, 1);
        check("prereset_count", fifo_count, 1);
        nRST = 1'b0;
        step();
        check("midrst_wr", bus.wr, 0);
        check("midrst_oe", bus.data_oe, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_data", bus.data_out, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_drops", drop_count, 0);
        nRST = 1'b1;
        step(2);

        // Partial word must not resurface after reset.
        base = got.size();
        push(32'h0BADF00D);
        wait_drained("postrst", 200);
        add_word(32'h0BADF00D);
        check_bytes("postrst", base);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
